// File: rtl/opl3_arb_pkg.sv
// Shared types for the OPL3 register-write arbiter: FSM states, port widths
// and the captured write record.
package opl3_arb_pkg;

    localparam int OPL3_ADDR_W = 9;
    localparam int OPL3_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        SPACE = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic [OPL3_ADDR_W-1:0] addr;
        logic [OPL3_DATA_W-1:0] data;
    } opl3_reg_wr_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request scanning upward from
// the slot after last_grant, wrapping at NUM_REQ.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    input  logic               enable,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

    localparam int SW = IDX_W + 2;

    logic [IDX_W-1:0]   cand_idx [NUM_REQ];
    logic [NUM_REQ-1:0] cand_req;

    // Candidate gi is the requester gi+1 places after the last winner.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_cand
            logic [SW-1:0] sum;
            assign sum          = SW'(last_grant) + SW'(gi + 1);
            assign cand_idx[gi] = (sum >= SW'(NUM_REQ)) ? IDX_W'(sum - SW'(NUM_REQ))
                                                        : IDX_W'(sum);
            assign cand_req[gi] = req[cand_idx[gi]];
        end
    endgenerate

    always_comb begin
        grant     = '0;
        grant_idx = last_grant;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (cand_req[k]) begin
                grant_idx = cand_idx[k];
            end
        end
        if (enable && (|cand_req)) begin
            grant[grant_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/opl3_reg_write_arbiter.sv
// Shares the single OPL3 register-write port among NUM_REQ requesters with
// round-robin grants, a one-cycle strobe and an enforced post-write gap.
module opl3_reg_write_arbiter
    import opl3_arb_pkg::*;
#(
    parameter int NUM_REQ       = 2,
    parameter int WRITE_SPACING = 32,
    parameter int CNT_W         = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*9-1:0]         req_addr,
    input  logic [NUM_REQ*8-1:0]         req_data,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic                         pause,
    output logic                         opl3_wr,
    output logic [8:0]                   opl3_addr,
    output logic [7:0]                   opl3_data,
    output logic                         busy,
    output logic [$clog2(NUM_REQ)-1:0]   last_grant,
    output logic [CNT_W-1:0]             write_count
);

    localparam int IDX_W      = $clog2(NUM_REQ);
    localparam int SPACE_LOAD = (WRITE_SPACING > 0) ? WRITE_SPACING - 1 : 0;

    arb_state_t         state_reg, state_next;
    logic [15:0]        space_cnt_reg, space_cnt_next;
    opl3_reg_wr_t       wr_reg;
    opl3_reg_wr_t       winner_wr;
    logic [IDX_W-1:0]   last_grant_reg;
    logic [IDX_W-1:0]   grant_idx;
    logic [CNT_W-1:0]   write_count_reg;
    logic [NUM_REQ-1:0] grant;
    logic               arb_enable;
    logic               accept;

    // Reset gates the grant so req_ready reads 0 while reset is held.
    assign arb_enable = (state_reg == IDLE) && !pause && !reset;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req        (req_valid),
        .last_grant (last_grant_reg),
        .enable     (arb_enable),
        .grant      (grant),
        .grant_idx  (grant_idx)
    );

    assign accept         = |(grant & req_valid);
    assign winner_wr.addr = req_addr[int'(grant_idx) * OPL3_ADDR_W +: OPL3_ADDR_W];
    assign winner_wr.data = req_data[int'(grant_idx) * OPL3_DATA_W +: OPL3_DATA_W];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            space_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            space_cnt_reg <= space_cnt_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        space_cnt_next = space_cnt_reg;
        req_ready      = grant & req_valid;
        opl3_wr        = 1'b0;
        busy           = 1'b1;
        case (state_reg)
            IDLE: begin
                busy = 1'b0;
                if (accept) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                opl3_wr = 1'b1;
                if (WRITE_SPACING == 0) begin
                    state_next = IDLE;
                end else begin
                    state_next     = SPACE;
                    space_cnt_next = 16'(SPACE_LOAD);
                end
            end
            SPACE: begin
                // Counter starts at WRITE_SPACING-1, so the gap is WRITE_SPACING cycles.
                if (space_cnt_reg == '0) begin
                    state_next = IDLE;
                end else begin
                    space_cnt_next = space_cnt_reg - 16'd1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_reg          <= '0;
            last_grant_reg  <= IDX_W'(NUM_REQ - 1);
            write_count_reg <= '0;
        end else if (accept) begin
            wr_reg          <= winner_wr;
            last_grant_reg  <= grant_idx;
            write_count_reg <= write_count_reg + CNT_W'(1);
        end
    end

    assign opl3_addr   = wr_reg.addr;
    assign opl3_data   = wr_reg.data;
    assign last_grant  = last_grant_reg;
    assign write_count = write_count_reg;

endmodule
